// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - shared types and PC field helpers for the BTB tag store
package btb_pkg;

    typedef enum logic {
        BTB_FLUSH = 1'b0,
        BTB_READY = 1'b1
    } btb_state_t;

    // Callers size the result down to IDX_W / TAG_W.
    function automatic logic [63:0] btb_idx(input logic [63:0] pc, input int unsigned idx_w);
        return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    function automatic logic [63:0] btb_tag(input logic [63:0] pc, input int unsigned idx_w,
                                            input int unsigned tag_w);
        return (pc >> (idx_w + 2)) & ((64'd1 << tag_w) - 64'd1);
    endfunction

endpackage

// File: rtl/btb_tag_bank.sv
// rtl/btb_tag_bank.sv - one way of tag/valid storage, registered read, no array reset
module btb_tag_bank #(
    parameter int SETS   = 1024,
    parameter int DATA_W = 21,
    localparam int IDX_W = $clog2(SETS)
) (
    input  logic              i_clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [SETS];

    // Read returns the pre-write contents; the top bypasses same-set writes.
    always_ff @(posedge i_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/btb_tag_store.sv
// rtl/btb_tag_store.sv - set-associative BTB tag/valid store with built-in flush sequencer
module btb_tag_store
    import btb_pkg::*;
#(
    parameter int SETS  = 1024,
    parameter int WAYS  = 2,
    parameter int TAG_W = 20,
    parameter int PC_W  = 32,
    localparam int IDX_W = $clog2(SETS),
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    output logic             o_ready,
    input  logic             i_lkp_en,
    input  logic [PC_W-1:0]  i_lkp_pc,
    output logic             o_hit,
    output logic [WAY_W-1:0] o_hit_way,
    input  logic             i_upd_en,
    input  logic [PC_W-1:0]  i_upd_pc,
    input  logic             i_upd_hit,
    input  logic [WAY_W-1:0] i_upd_way,
    input  logic             i_upd_inv
);

    if (PC_W < TAG_W + IDX_W + 2) begin : g_pc_w_check
        $error("btb_tag_store: PC_W too small for TAG_W+IDX_W+2");
    end
    if (WAYS < 1 || WAYS > 8 || (WAYS & (WAYS - 1)) != 0) begin : g_ways_check
        $error("btb_tag_store: WAYS must be a power of 2 in 1..8");
    end
    if (SETS < 2 || (SETS & (SETS - 1)) != 0) begin : g_sets_check
        $error("btb_tag_store: SETS must be a power of 2, at least 2");
    end

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } btb_entry_t;

    btb_state_t       state;
    logic [IDX_W-1:0] flush_ctr;
    logic [WAY_W-1:0] rr [SETS];

    logic [IDX_W-1:0] lkp_idx, upd_idx;
    logic [TAG_W-1:0] lkp_tag, upd_tag;

    assign lkp_idx = IDX_W'(btb_idx(64'(i_lkp_pc), IDX_W));
    assign upd_idx = IDX_W'(btb_idx(64'(i_upd_pc), IDX_W));
    assign lkp_tag = TAG_W'(btb_tag(64'(i_lkp_pc), IDX_W, TAG_W));
    assign upd_tag = TAG_W'(btb_tag(64'(i_upd_pc), IDX_W, TAG_W));

    logic             flushing;
    logic             upd_valid;
    logic             rr_adv;
    logic [WAY_W-1:0] victim;
    logic [WAY_W-1:0] target_way;
    logic [IDX_W-1:0] waddr;
    btb_entry_t       wdata;

    assign flushing   = (state == BTB_FLUSH);
    // A flush request in the same cycle as an update takes priority.
    assign upd_valid  = (state == BTB_READY) && i_upd_en && !i_flush;
    assign victim     = (WAYS > 1) ? rr[upd_idx] : '0;
    assign target_way = (i_upd_inv || i_upd_hit) ? i_upd_way : victim;
    assign rr_adv     = (WAYS > 1) && upd_valid && !i_upd_inv && !i_upd_hit;
    assign waddr      = flushing ? flush_ctr : upd_idx;
    assign wdata      = flushing ? '0 : btb_entry_t'{valid: !i_upd_inv, tag: upd_tag};

    btb_entry_t rd_data [WAYS];

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic we;
        assign we = flushing || (upd_valid && (target_way == WAY_W'(w)));

        btb_tag_bank #(
            .SETS   (SETS),
            .DATA_W (TAG_W + 1)
        ) u_bank (
            .i_clk (i_clk),
            .we    (we),
            .waddr (waddr),
            .wdata (wdata),
            .raddr (lkp_idx),
            .rdata (rd_data[w])
        );
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= BTB_FLUSH;
            flush_ctr <= '0;
        end else begin
            case (state)
                BTB_FLUSH: begin
                    if (i_flush) begin
                        flush_ctr <= '0;
                    end else if (flush_ctr == IDX_W'(SETS - 1)) begin
                        state     <= BTB_READY;
                        flush_ctr <= '0;
                    end else begin
                        flush_ctr <= flush_ctr + 1'b1;
                    end
                end
                BTB_READY: begin
                    if (i_flush) begin
                        state     <= BTB_FLUSH;
                        flush_ctr <= '0;
                    end
                end
                default: state <= BTB_FLUSH;
            endcase
        end
    end

    assign o_ready = (state == BTB_READY);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int s = 0; s < SETS; s++) begin
                rr[s] <= '0;
            end
        end else if (rr_adv) begin
            rr[upd_idx] <= rr[upd_idx] + 1'b1;
        end
    end

    logic             lkp_v_q;
    logic [TAG_W-1:0] lkp_tag_q;
    logic             byp_en_q;
    logic [WAY_W-1:0] byp_way_q;
    btb_entry_t       byp_data_q;

    // Captures a same-cycle write to the looked-up set so the result is write-first.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            lkp_v_q    <= 1'b0;
            lkp_tag_q  <= '0;
            byp_en_q   <= 1'b0;
            byp_way_q  <= '0;
            byp_data_q <= '0;
        end else begin
            lkp_v_q    <= i_lkp_en && (state == BTB_READY);
            lkp_tag_q  <= lkp_tag;
            byp_en_q   <= upd_valid && (upd_idx == lkp_idx);
            byp_way_q  <= target_way;
            byp_data_q <= wdata;
        end
    end

    always_comb begin
        btb_entry_t ent;
        o_hit     = 1'b0;
        o_hit_way = '0;
        ent       = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            ent = (byp_en_q && (byp_way_q == WAY_W'(w))) ? byp_data_q : rd_data[w];
            if (lkp_v_q && ent.valid && (ent.tag == lkp_tag_q)) begin
                o_hit     = 1'b1;
                o_hit_way = WAY_W'(w);
            end
        end
    end

endmodule
